// File: rtl/z80_trace_pkg.sv
// Shared types for the Z80 bus tracer: cycle encoding, trace record and strobe decoder.
package z80_trace_pkg;

   localparam int TS_MAX = 32;

   typedef enum logic [2:0] {
      OPFETCH = 3'd0,
      MEMRD   = 3'd1,
      MEMWR   = 3'd2,
      IORD    = 3'd3,
      IOWR    = 3'd4,
      INTACK  = 3'd5
   } bus_cycle_e;

   // ts is held at its widest size; the top level zero-extends and truncates to TS_W.
   typedef struct packed {
      bus_cycle_e        typ;
      logic [15:0]       addr;
      logic [7:0]        data;
      logic [TS_MAX-1:0] ts;
   } trace_rec_t;

   localparam int REC_W = $bits(trace_rec_t);

   typedef struct packed {
      logic       vld;
      bus_cycle_e typ;
   } bus_dec_t;

   function automatic bus_dec_t bus_decode(input logic m1_n, input logic mreq_n,
                                           input logic iorq_n, input logic rd_n,
                                           input logic wr_n, input logic rfsh_n);
      bus_dec_t d;
      d.vld = 1'b1;
      d.typ = OPFETCH;
      if (!rfsh_n)                     d.vld = 1'b0;
      else if (!m1_n && !iorq_n)       d.typ = INTACK;
      else if (!m1_n && !mreq_n && !rd_n) d.typ = OPFETCH;
      else if (!mreq_n && !rd_n)       d.typ = MEMRD;
      else if (!mreq_n && !wr_n)       d.typ = MEMWR;
      else if (!iorq_n && !rd_n)       d.typ = IORD;
      else if (!iorq_n && !wr_n)       d.typ = IOWR;
      else                             d.vld = 1'b0;
      return d;
   endfunction

   function automatic logic is_write(input bus_cycle_e t);
      return (t == MEMWR) || (t == IOWR);
   endfunction

endpackage

// File: rtl/z80_trace_fifo.sv
// Synchronous FIFO of trace records with a registered head; a new entry reaches the head one clk after its write.
module z80_trace_fifo
   import z80_trace_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       push_i,
   input  trace_rec_t wdata_i,
   input  logic       ready_i,
   output logic       full_o,
   output logic       empty_o,
   output logic       valid_o,
   output trace_rec_t head_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   trace_rec_t    mem_q [DEPTH];
   trace_rec_t    head_q;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d, left;
   logic          valid_q, pop, wr;

   assign pop      = valid_q && ready_i;
   assign full_o   = (cnt_q == CW'(DEPTH));
   assign empty_o  = (cnt_q == '0);
   assign wr       = push_i && (!full_o || pop);
   assign rd_ptr_d = rd_ptr_q + AW'(pop);
   assign cnt_d    = cnt_q + CW'(wr) - CW'(pop);
   // Entries left after this pop, ignoring this edge's write: that is what keeps the bypass out.
   assign left     = cnt_q - CW'(pop);

   always_ff @(posedge clk) begin
      if (wr) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + AW'(wr);
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         valid_q  <= (left != '0);
         if (left != '0) head_q <= mem_q[rd_ptr_d];
      end
   end

   assign valid_o = valid_q;
   assign head_o  = head_q;

endmodule

// File: rtl/z80_bus_tracer.sv
// Passive Z80 bus monitor: decodes each completed bus cycle into a timestamped record queued for a host.
module z80_bus_tracer
   import z80_trace_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int TS_W  = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            cen,
   input  logic            trace_en,
   input  logic            m1_n,
   input  logic            mreq_n,
   input  logic            iorq_n,
   input  logic            rd_n,
   input  logic            wr_n,
   input  logic            rfsh_n,
   input  logic [15:0]     A,
   input  logic [7:0]      di,
   input  logic [7:0]      dout,
   output logic            rec_valid,
   input  logic            rec_ready,
   output logic [2:0]      rec_type,
   output logic [15:0]     rec_addr,
   output logic [7:0]      rec_data,
   output logic [TS_W-1:0] rec_ts,
   output logic            overflow,
   output logic [7:0]      drop_cnt,
   input  logic            clr_ovf
);

   typedef enum logic {S_IDLE, S_ACTIVE} state_e;

   state_e          state_q;
   trace_rec_t      cur_q, head;
   logic [TS_W-1:0] ts_q;
   logic            ovf_q;
   logic [7:0]      drop_q;
   bus_dec_t        dec;
   logic [7:0]      smp;
   logic            active, same, push, start, full, fifo_empty, drop, unused_ok;

   assign dec    = bus_decode(m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n);
   assign smp    = is_write(dec.typ) ? dout : di;
   assign active = (state_q == S_ACTIVE);
   assign same   = dec.vld && (dec.typ == cur_q.typ);
   assign push   = cen && active && !same;
   assign start  = cen && dec.vld && trace_en && !(active && same);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cur_q   <= '0;
         ts_q    <= '0;
      end else if (cen) begin
         ts_q <= ts_q + TS_W'(1);
         if (start) begin
            state_q    <= S_ACTIVE;
            cur_q.typ  <= dec.typ;
            cur_q.addr <= A;
            cur_q.data <= smp;
            cur_q.ts   <= TS_MAX'(ts_q);
         end else if (active && same) begin
            cur_q.data <= smp;
         end else if (push) begin
            state_q <= S_IDLE;
         end
      end
   end

   // A pop on the same edge frees the slot, so only an unpopped full FIFO drops.
   assign drop = push && full && !(rec_valid && rec_ready);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf_q  <= 1'b0;
         drop_q <= '0;
      end else if (clr_ovf) begin
         ovf_q  <= 1'b0;
         drop_q <= '0;
      end else if (drop) begin
         ovf_q <= 1'b1;
         if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
   end

   z80_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push),
      .wdata_i (cur_q),
      .ready_i (rec_ready),
      .full_o  (full),
      .empty_o (fifo_empty),
      .valid_o (rec_valid),
      .head_o  (head)
   );

   assign rec_type  = head.typ;
   assign rec_addr  = head.addr;
   assign rec_data  = head.data;
   assign rec_ts    = head.ts[TS_W-1:0];
   assign overflow  = ovf_q;
   assign drop_cnt  = drop_q;
   assign unused_ok = ^{fifo_empty, head.ts};

endmodule

// File: tb/tb_z80_bus_tracer.sv
// Scoreboard bench for z80_bus_tracer: expected records queued at drive time, compared on each pop.
module tb_z80_bus_tracer;

   logic        clk = 1'b0, reset_n = 1'b0, cen = 1'b1, trace_en = 1'b1;
   logic        m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1;
   logic [15:0] A = '0;
   logic [7:0]  di = '0, dout = '0;
   logic        rec_ready = 1'b0, clr_ovf = 1'b0;
   logic        rec_valid, overflow;
   logic [2:0]  rec_type;
   logic [15:0] rec_addr;
   logic [7:0]  rec_data, drop_cnt;
   logic [3:0]  rec_ts;

   z80_bus_tracer #(.DEPTH(4), .TS_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .cen(cen), .trace_en(trace_en),
      .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
      .A(A), .di(di), .dout(dout),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_type(rec_type), .rec_addr(rec_addr),
      .rec_data(rec_data), .rec_ts(rec_ts), .overflow(overflow), .drop_cnt(drop_cnt),
      .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  typ;
      logic [15:0] addr;
      logic [7:0]  data;
      logic [3:0]  ts;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0, n_err = 0;

   // Reference cycle counter: counts enabled clocks since reset, modulo 16.
   logic [3:0] tsm = '0;
   always @(posedge clk or negedge reset_n)
      if (!reset_n) tsm <= '0;
      else if (cen) tsm <= tsm + 4'd1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      #1;
      if (reset_n && rec_valid && rec_ready) begin
         if (sb.size() == 0) chk("unexpected_rec", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            chk("rec_type", rec_type, e.typ);
            chk("rec_addr", rec_addr, e.addr);
            chk("rec_data", rec_data, e.data);
            chk("rec_ts",   rec_ts,   e.ts);
         end
      end
   end

   task automatic set_bus(input logic [2:0] t);
      m1_n = 1; mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1; rfsh_n = 1;
      case (t)
         3'd0: begin m1_n = 0; mreq_n = 0; rd_n = 0; end
         3'd1: begin mreq_n = 0; rd_n = 0; end
         3'd2: begin mreq_n = 0; wr_n = 0; end
         3'd3: begin iorq_n = 0; rd_n = 0; end
         3'd4: begin iorq_n = 0; wr_n = 0; end
         3'd5: begin m1_n = 0; iorq_n = 0; end
         default: ;
      endcase
   endtask

   // Two-clock strobe: wrong data and the address held on the first edge, real data and a
   // scrambled address on the second. Fetches get a refresh cycle. Returns at the push negedge.
   task automatic bus(input logic [2:0] t, input logic [15:0] a, input logic [7:0] d,
                      input bit keep = 1, input bit en_drop = 0);
      bit w;
      w = (t == 3'd2) || (t == 3'd4);
      @(negedge clk);
      set_bus(t); A = a; di = ~d; dout = ~d;
      if (keep) sb.push_back('{t, a, d, tsm});
      @(negedge clk);
      A = a ^ 16'h5555;
      di   = w ? ~d : d;
      dout = w ? d : ~d;
      if (en_drop) trace_en = 0;
      @(negedge clk);
      set_bus(3'd7);
      if (t == 3'd0) begin
         rfsh_n = 0; mreq_n = 0; A = 16'h007F;
         @(negedge clk);
         set_bus(3'd7);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic gap(input int n);
      @(negedge clk);
      cen = 0;
      repeat (n) @(negedge clk);
      cen = 1;
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while (sb.size() != 0 && k < 60) begin
         @(negedge clk);
         k++;
      end
      chk(tag, sb.size(), 0);
      idle(2);
   endtask

   initial begin
      idle(2);
      chk("rst_valid", rec_valid, 0);
      chk("rst_ovf",   overflow,  0);
      chk("rst_drop",  drop_cnt,  0);
      chk("rst_head",  {rec_type, rec_addr, rec_data, rec_ts}, 0);
      reset_n = 1;
      idle(1);
      chk("post_rst_valid", rec_valid, 0);

      // CB C8 fetch pair, then a memory write and an I/O read
      rec_ready = 1;
      bus(3'd0, 16'h0000, 8'hCB);
      bus(3'd0, 16'h0001, 8'hC8);
      drain("fetch_drain");
      bus(3'd2, 16'h7CF3, 8'h75);
      idle(3);
      bus(3'd3, 16'h0012, 8'h5A);
      bus(3'd5, 16'h00FF, 8'hE7);
      drain("memio_drain");

      // Overflow: four retained, two dropped
      rec_ready = 0;
      for (int i = 0; i < 6; i++)
         bus(3'(i % 6), 16'h1000 + 16'(i), 8'h10 + 8'(i), i < 4);
      idle(2);
      chk("ovf_set",  overflow, 1);
      chk("drop_two", drop_cnt, 2);
      rec_ready = 1;
      drain("ovf_drain");
      @(negedge clk) clr_ovf = 1;
      @(negedge clk) clr_ovf = 0;
      chk("clr_ovf",  overflow, 0);
      chk("clr_drop", drop_cnt, 0);

      // Pop on the same edge as a push into a full FIFO
      rec_ready = 0;
      for (int i = 0; i < 4; i++) bus(3'd1, 16'h4000 + 16'(i), 8'h40 + 8'(i));
      bus(3'd4, 16'h4004, 8'h44);
      rec_ready = 1;
      idle(2);
      chk("full_pop_ovf",  overflow, 0);
      chk("full_pop_drop", drop_cnt, 0);
      drain("full_pop_drain");

      // Clear on the same edge as a drop
      rec_ready = 0;
      for (int i = 0; i < 4; i++) bus(3'd3, 16'h5000 + 16'(i), 8'h50 + 8'(i));
      bus(3'd2, 16'h5004, 8'h54, 0);
      clr_ovf = 1;
      @(negedge clk) clr_ovf = 0;
      idle(1);
      chk("clr_win_ovf",  overflow, 0);
      chk("clr_win_drop", drop_cnt, 0);
      rec_ready = 1;
      drain("clr_win_drain");

      // trace_en dropped mid-cycle: that record completes, later ones are skipped
      bus(3'd1, 16'h2000, 8'hA1, 1, 1);
      bus(3'd4, 16'h2001, 8'hB2, 0);
      bus(3'd2, 16'h2002, 8'hB3, 0);
      trace_en = 1;
      bus(3'd1, 16'h2003, 8'hC3);
      drain("trace_en_drain");

      // Timestamp wrap over 20 idle enabled cycles, with frozen cen gaps mixed in
      bus(3'd0, 16'h3000, 8'h11);
      idle(7);
      gap(5);
      idle(6);
      gap(3);
      idle(4);
      bus(3'd0, 16'h3001, 8'h22);
      drain("ts_drain");

      // Reset with three records queued
      rec_ready = 0;
      for (int i = 0; i < 3; i++) bus(3'd2, 16'h6000 + 16'(i), 8'h60 + 8'(i));
      idle(2);
      chk("pre_rst_valid", rec_valid, 1);
      @(negedge clk) reset_n = 0;
      #1;
      chk("midrst_valid", rec_valid, 0);
      chk("midrst_ovf",   overflow,  0);
      chk("midrst_ts",    rec_ts,    0);
      sb.delete();
      @(negedge clk) reset_n = 1;
      rec_ready = 1;
      bus(3'd3, 16'h0042, 8'h99);
      drain("post_rst_drain");
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule

// File: doc/z80_bus_tracer.md
# z80_bus_tracer

Passive bus-cycle monitor hooked to the tv80s CPU bus pins, downstream of the CPU in the test harness. It decodes each completed Z80 bus transaction (opcode fetch, memory read/write, I/O read/write, interrupt acknowledge) into one record of type, address, data and cycle timestamp. Records are queued in an internal FIFO that the bench or a host port drains through a valid/ready interface. The block never drives the CPU bus.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- TS_W, 16: timestamp width in bits.

Ports:
- clk  in  1  system clock; same clock as the CPU.
- reset_n  in  1  asynchronous, active-low reset.
- cen  in  1  CPU clock enable; the block samples the bus and advances the timestamp only when cen=1.
- trace_en  in  1  when 0, no new transaction is started; a transaction already in flight completes and is pushed.
- m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  in  1 each  CPU bus strobes.
- A  in  16  CPU address bus.
- di  in  8  data into the CPU (read data).
- dout  in  8  data out of the CPU (write data).
- rec_valid  out  1  FIFO head record is valid.
- rec_ready  in  1  consumer accepts the head when rec_valid=1 and rec_ready=1.
- rec_type  out  3  cycle type of the head record.
- rec_addr  out  16  address of the head record.
- rec_data  out  8  data of the head record.
- rec_ts  out  TS_W  timestamp of the head record.
- overflow  out  1  sticky flag: a record was dropped.
- drop_cnt  out  8  number of dropped records; saturates at 0xFF.
- clr_ovf  in  1  synchronous clear of overflow and drop_cnt.

## Operation
Cycle decode, evaluated in priority order on clk rising edges with cen=1:
- rfsh_n=0: refresh cycle; ignored.
- m1_n=0 and iorq_n=0: INTACK (5).
- m1_n=0 and mreq_n=0 and rd_n=0: OPFETCH (0).
- mreq_n=0 and rd_n=0: MEMRD (1).
- mreq_n=0 and wr_n=0: MEMWR (2).
- iorq_n=0 and rd_n=0: IORD (3).
- iorq_n=0 and wr_n=0: IOWR (4).
- All other combinations: no strobe.

State machine: IDLE, ACTIVE.
- IDLE → ACTIVE: a strobe is decoded and trace_en=1. On this transition the block latches the type, A and the current timestamp.
- ACTIVE: on every cen cycle while the strobe holds, the data register loads di for read types (OPFETCH, MEMRD, IORD, INTACK) or dout for write types. The last sampled value wins.
- ACTIVE → IDLE: the decoded strobe drops or changes type. The latched record is pushed on that edge.
- If a new strobe is decoded on the same edge as the push and trace_en=1, the block latches the new transaction and stays in ACTIVE.
- A changes while ACTIVE: the address latched at start is kept.

Timestamp: free-running TS_W-bit counter. It increments on each clk with cen=1 and wraps to 0 after all-ones. It runs regardless of trace_en.

FIFO:
- Push when not full: the record is written.
- Push when full: the record is dropped, overflow sets, drop_cnt increments (saturating).
- Push and pop on the same edge while full: the push is accepted; no drop.
- Pop when empty: no effect.
- clr_ovf takes effect on the same edge as a drop: clr_ovf wins for overflow, and drop_cnt becomes 0.

Reset (async assert, sync deassert by the environment) sets:
- state IDLE, timestamp 0, FIFO empty;
- rec_valid 0, rec_type/addr/data/ts 0;
- overflow 0, drop_cnt 0.

## Timing
- Push occurs on the first cen edge at which the strobe is seen deasserted.
- rec_valid rises one clk after the push into an empty FIFO. There is no fall-through bypass.
- rec_* fields are registered FIFO head outputs. They stay stable while rec_valid=1 and rec_ready=0.
- A pop with rec_ready=1 presents the next entry on the following clk.
- Sustained throughput: one pop per clk.
- cen=0: bus sampling, the FSM and the timestamp freeze. The FIFO read side still operates.

## Structure
Shared package z80_trace_pkg contains:
- enum bus_cycle_e (3 bits, encodings listed above);
- struct trace_rec_t {type, addr, data, ts};
- localparam REC_W.

Sub-module z80_trace_fifo: a parameterised synchronous FIFO of trace_rec_t with full/empty flags and registered head output. The top level holds the decoder, FSM, timestamp counter and overflow logic.

## Test plan
- Reset mid-trace: assert reset_n=0 with 3 records queued → rec_valid=0 immediately, overflow=0, timestamp restarts at 0 after release.
- tv80s executing CB C8 at 0000h with rec_ready=1 → two OPFETCH records {0000h, CBh} then {0001h, C8h}; timestamps strictly increasing. No record is produced for the refresh cycles.
- Injected MEMWR 7CF3h←75h, then IORD port 0012h returning 5Ah → records {MEMWR, 7CF3h, 75h} and {IORD, 0012h, 5Ah}; rec_ts difference equals the cen count between their starts.
- DEPTH=4, rec_ready=0, 6 transactions → 4 records retained in order, overflow=1, drop_cnt=2. Then clr_ovf → 0/0. Raising rec_ready on the edge of a full push → no drop.
- trace_en dropped mid-MEMRD → that record is still pushed; subsequent cycles are not traced until trace_en=1.
- TS_W=4 with 20 cen cycles of idle between two fetches → second rec_ts equals the first +20 mod 16. cen=0 gaps do not advance the timestamp.
